// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared types and constants for the CPU/DMA memory-port arbiter.
//   - state_t      : arbiter FSM states
//   - REQ_CPU/DMA  : requester indices used in request/grant vectors
//   - req_t        : one requester's access descriptor (wr/addr/wdata/be)
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;

    localparam int ADDR_W = 23;   // word address [23:1]
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;    // {high, low}
    localparam int CNT_W  = 4;    // holds WAIT_CYCLES up to 15

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the two requester ports and the shared memory port.
//   modport slave  : the arbiter (takes requests + mem_rdata, drives acks,
//                    read data and the memory-port controls)
//   modport master : the environment (requesters and the memory itself)
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // CPU requester
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [BE_W-1:0]   cpu_be;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    // DMA requester
    logic              dma_req;
    logic              dma_wr;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [BE_W-1:0]   dma_be;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;

    // Shared memory port
    logic              mem_cs;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_high;
    logic              mem_low;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, cpu_be,
        input  dma_req, dma_wr, dma_addr, dma_wdata, dma_be,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        output mem_cs, mem_wr, mem_addr, mem_wdata, mem_high, mem_low
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata, cpu_be,
        output dma_req, dma_wr, dma_addr, dma_wdata, dma_be,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        input  mem_cs, mem_wr, mem_addr, mem_wdata, mem_high, mem_low
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin selector, purely combinational.
//   req        : request vector, bit REQ_CPU / REQ_DMA
//   last_grant : index of the requester granted most recently
//   grant      : one-hot grant (all zero when nobody requests)
//   A lone request always wins; on a tie the requester that was not
//   granted last wins.
// ---------------------------------------------------------------------------
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[REQ_CPU] && req[REQ_DMA]) begin
            if (last_grant == 1'(REQ_DMA))
                grant[REQ_CPU] = 1'b1;
            else
                grant[REQ_DMA] = 1'b1;
        end else if (req[REQ_CPU]) begin
            grant[REQ_CPU] = 1'b1;
        end else if (req[REQ_DMA]) begin
            grant[REQ_DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between a CPU and a DMA requester.
//   Parameters:
//     WAIT_CYCLES : extra memory cycles held per access (0..15)
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous active-high reset
//     bus : mem_arbiter_if.slave (requester handshakes + memory port)
//   Timeline for a request sampled in IDLE at edge t0:
//     cycles after t0 .. t0+WAIT_CYCLES : ACCESS, mem_cs high
//     edge t0+WAIT_CYCLES+1            : mem_rdata captured, -> DONE
//     edge t0+WAIT_CYCLES+2            : ack + rdata update, -> IDLE
//   The ack cycle is itself an IDLE cycle, so a req still high there is
//   treated as a fresh request at the following edge.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    import mem_arbiter_pkg::*;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               last_grant;   // requester index granted last
    logic               gnt_dma;      // current access belongs to DMA
    logic               txn_wr;       // current access is a write
    logic [DATA_W-1:0]  rd_hold;      // read data captured on last ACCESS cycle

    logic [1:0]         req_vec;
    logic [1:0]         grant;
    req_t               cpu_r;
    req_t               dma_r;
    req_t               sel_r;

    assign req_vec[REQ_CPU] = bus.cpu_req;
    assign req_vec[REQ_DMA] = bus.dma_req;

    assign cpu_r = '{wr: bus.cpu_wr, addr: bus.cpu_addr, wdata: bus.cpu_wdata, be: bus.cpu_be};
    assign dma_r = '{wr: bus.dma_wr, addr: bus.dma_addr, wdata: bus.dma_wdata, be: bus.dma_be};
    assign sel_r = grant[REQ_DMA] ? dma_r : cpu_r;

    rr_arbiter2 u_rr (
        .req        (req_vec),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            last_grant    <= 1'(REQ_DMA);   // so the CPU wins the first tie
            gnt_dma       <= 1'b0;
            txn_wr        <= 1'b0;
            rd_hold       <= '0;
            bus.mem_cs    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_high  <= 1'b0;
            bus.mem_low   <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.dma_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.dma_rdata <= '0;
        end else begin
            // acks are single-cycle pulses raised only from DONE
            bus.cpu_ack <= 1'b0;
            bus.dma_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (|grant) begin
                        gnt_dma       <= grant[REQ_DMA];
                        last_grant    <= grant[REQ_DMA];
                        txn_wr        <= sel_r.wr;
                        cnt           <= CNT_W'(WAIT_CYCLES);
                        // memory-port drive is registered here and held
                        // untouched for the whole ACCESS window
                        bus.mem_cs    <= 1'b1;
                        bus.mem_wr    <= sel_r.wr;
                        bus.mem_addr  <= sel_r.addr;
                        bus.mem_wdata <= sel_r.wdata;
                        bus.mem_high  <= sel_r.be[1];
                        bus.mem_low   <= sel_r.be[0];
                        state         <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (cnt == '0) begin
                        rd_hold      <= bus.mem_rdata;
                        bus.mem_cs   <= 1'b0;
                        bus.mem_wr   <= 1'b0;
                        bus.mem_high <= 1'b0;
                        bus.mem_low  <= 1'b0;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    // rdata moves together with the ack so it stays valid
                    // from one ack to the next for that requester
                    if (gnt_dma) begin
                        bus.dma_ack <= 1'b1;
                        if (!txn_wr) bus.dma_rdata <= rd_hold;
                    end else begin
                        bus.cpu_ack <= 1'b1;
                        if (!txn_wr) bus.cpu_rdata <= rd_hold;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter_if bus0 ();

    mem_arbiter #(.WAIT_CYCLES(W)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    mem_arbiter #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory read data drivers ----------------
    bit          rnd_rd = 1'b0;
    logic [15:0] fix_rd = 16'h0;
    logic [15:0] fix_rd0 = 16'h0;
    always @(negedge clk) begin
        bus.mem_rdata  = rnd_rd ? 16'($urandom) : fix_rd;
        bus0.mem_rdata = fix_rd0;
    end

    // ---------------- transaction-level reference model ----------------
    // A request sampled at edge t0 owns the port for the cycles following
    // edges t0..t0+W, its read data is whatever mem_rdata is at edge
    // t0+W+1, and its ack/rdata appear after edge t0+W+2.
    int          n = 0;
    bit          m_valid = 1'b0, m_busy = 1'b0, m_g = 1'b0, m_last = 1'b1, m_wr = 1'b0;
    int          m_t0 = 0;
    logic [22:0] m_addr = '0;
    logic [15:0] m_wdata = '0, m_hold = '0, m_crd = '0, m_drd = '0;
    logic [1:0]  m_be = '0;
    bit          e_cack = 1'b0, e_dack = 1'b0, e_rst = 1'b0, e_cs = 1'b0;

    always @(posedge clk) begin
        n++;
        e_cack = 1'b0;
        e_dack = 1'b0;
        e_rst  = 1'b0;
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_last  = 1'b1;
            m_crd   = '0;
            m_drd   = '0;
            e_rst   = 1'b1;
        end else if (m_busy) begin
            if (n == m_t0 + W + 1) m_hold = bus.mem_rdata;
            if (n == m_t0 + W + 2) begin
                if (m_g) e_dack = 1'b1; else e_cack = 1'b1;
                if (!m_wr) begin
                    if (m_g) m_drd = m_hold; else m_crd = m_hold;
                end
                m_busy = 1'b0;
            end
        end else if (bus.cpu_req || bus.dma_req) begin
            m_g    = (bus.cpu_req && bus.dma_req) ? ~m_last : bus.dma_req;
            m_last = m_g;
            m_t0   = n;
            m_busy = 1'b1;
            m_wr    = m_g ? bus.dma_wr    : bus.cpu_wr;
            m_addr  = m_g ? bus.dma_addr  : bus.cpu_addr;
            m_wdata = m_g ? bus.dma_wdata : bus.cpu_wdata;
            m_be    = m_g ? bus.dma_be    : bus.cpu_be;
        end
        e_cs = m_busy && ((n - m_t0) <= W);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            chk("mem_cs",    32'(bus.mem_cs),   32'(e_cs));
            chk("mem_wr",    32'(bus.mem_wr),   32'(e_cs & m_wr));
            chk("mem_high",  32'(bus.mem_high), 32'(e_cs & m_be[1]));
            chk("mem_low",   32'(bus.mem_low),  32'(e_cs & m_be[0]));
            chk("cpu_ack",   32'(bus.cpu_ack),  32'(e_cack));
            chk("dma_ack",   32'(bus.dma_ack),  32'(e_dack));
            chk("ack_excl",  32'(bus.cpu_ack & bus.dma_ack), 32'd0);
            chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_crd));
            chk("dma_rdata", 32'(bus.dma_rdata), 32'(m_drd));
            if (e_cs) begin
                chk("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
                chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
            end
            if (e_rst) begin
                chk("rst_addr",  32'(bus.mem_addr),  32'd0);
                chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input bit wr, input logic [22:0] a, input logic [15:0] d, input logic [1:0] be);
        bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_be = be; bus.cpu_req = 1'b1;
    endtask

    task automatic set_dma(input bit wr, input logic [22:0] a, input logic [15:0] d, input logic [1:0] be);
        bus.dma_wr = wr; bus.dma_addr = a; bus.dma_wdata = d; bus.dma_be = be; bus.dma_req = 1'b1;
    endtask

    // Returns the edge index of the ack cycle (or -1) and how many cycles
    // mem_cs was seen high while waiting.
    task automatic wait_ack(input bit dma, output int edge_at, output int cs_cycles);
        edge_at   = -1;
        cs_cycles = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.mem_cs) cs_cycles++;
            if (dma ? bus.dma_ack : bus.cpu_ack) begin
                edge_at = n;
                break;
            end
        end
        if (edge_at < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: no %s ack within 60 cycles", dma ? "dma" : "cpu");
        end
    endtask

    task automatic rst_pulse();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int k0, e1, e2, cs;
        int order[$];
        int acks;

        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_be = '0;
        bus.dma_req = 0; bus.dma_wr = 0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.dma_be = '0;
        bus0.cpu_req = 0; bus0.cpu_wr = 0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0; bus0.cpu_be = '0;
        bus0.dma_req = 0; bus0.dma_wr = 0; bus0.dma_addr = '0; bus0.dma_wdata = '0; bus0.dma_be = '0;

        // reset state
        repeat (3) tick();
        @(negedge clk);
        chk("reset_cs",    32'(bus.mem_cs),    32'd0);
        chk("reset_ack",   32'({bus.cpu_ack, bus.dma_ack}), 32'd0);
        chk("reset_crd",   32'(bus.cpu_rdata), 32'd0);
        chk("reset_drd",   32'(bus.dma_rdata), 32'd0);
        chk("reset0_cs",   32'(bus0.mem_cs),   32'd0);
        tick(); rst = 1'b0;
        tick();

        // single CPU read
        fix_rd = 16'hBEEF;
        k0 = n;
        set_cpu(1'b0, 23'h0A0000, 16'h0, 2'b11);
        wait_ack(1'b0, e1, cs);
        bus.cpu_req = 1'b0;
        chk("rd_latency", 32'(e1 - k0), 32'd5);
        chk("rd_cs_cycles", 32'(cs), 32'd3);
        chk("rd_data", 32'(bus.cpu_rdata), 32'hBEEF);

        // simultaneous requests after reset: CPU first, then DMA
        rst_pulse();
        fix_rd = 16'h1111;
        k0 = n;
        set_cpu(1'b0, 23'h000010, 16'h0, 2'b11);
        set_dma(1'b0, 23'h000020, 16'h0, 2'b11);
        wait_ack(1'b0, e1, cs);
        bus.cpu_req = 1'b0;
        wait_ack(1'b1, e2, cs);
        bus.dma_req = 1'b0;
        chk("tie_cpu_latency", 32'(e1 - k0), 32'd5);
        chk("tie_dma_after", 32'(e2 - e1), 32'd5);
        chk("tie_dma_rdata", 32'(bus.dma_rdata), 32'h1111);

        // both held continuously: grants alternate
        rst_pulse();
        set_cpu(1'b0, 23'h000100, 16'h0, 2'b01);
        set_dma(1'b0, 23'h000200, 16'h0, 2'b10);
        acks = 0;
        for (int k = 0; k < 100 && acks < 6; k++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin order.push_back(0); acks++; end
            if (bus.dma_ack) begin order.push_back(1); acks++; end
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        chk("rr_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < 6 && i < order.size(); i++)
            chk("rr_order", 32'(order[i]), 32'(i % 2));

        // DMA write leaves dma_rdata alone
        tick();
        fix_rd = 16'hA5A5;
        set_dma(1'b0, 23'h000123, 16'h0, 2'b11);
        wait_ack(1'b1, e1, cs);
        bus.dma_req = 1'b0;
        chk("pre_wr_rdata", 32'(bus.dma_rdata), 32'hA5A5);
        tick();
        fix_rd = 16'hDEAD;
        set_dma(1'b1, 23'h1FF800, 16'h1234, 2'b10);
        cs = 0;
        e1 = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.mem_cs) begin
                cs++;
                chk("wr_mem_wr",   32'(bus.mem_wr),    32'd1);
                chk("wr_mem_high", 32'(bus.mem_high),  32'd1);
                chk("wr_mem_low",  32'(bus.mem_low),   32'd0);
                chk("wr_mem_addr", 32'(bus.mem_addr),  32'h1FF800);
                chk("wr_mem_data", 32'(bus.mem_wdata), 32'h1234);
            end
            if (bus.dma_ack) begin e1 = n; break; end
        end
        bus.dma_req = 1'b0;
        chk("wr_ack_seen", 32'(e1 >= 0), 32'd1);
        chk("wr_cs_cycles", 32'(cs), 32'd3);
        chk("wr_rdata_kept", 32'(bus.dma_rdata), 32'hA5A5);

        // reset in the second ACCESS cycle aborts without ack
        tick();
        fix_rd = 16'hBEEF;
        set_cpu(1'b0, 23'h000333, 16'h0, 2'b11);
        tick();
        tick();
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("abort_cs_before", 32'(bus.mem_cs), 32'd1);
        tick();
        rst = 1'b0;
        acks = 0;
        cs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.dma_ack) acks++;
            if (bus.mem_cs) cs++;
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        chk("abort_cs_low", 32'(cs), 32'd0);
        tick();
        fix_rd = 16'h5A5A;
        k0 = n;
        set_cpu(1'b0, 23'h000444, 16'h0, 2'b11);
        wait_ack(1'b0, e1, cs);
        bus.cpu_req = 1'b0;
        chk("post_abort_latency", 32'(e1 - k0), 32'd5);
        chk("post_abort_rdata", 32'(bus.cpu_rdata), 32'h5A5A);

        // zero-wait build
        tick();
        fix_rd0 = 16'hC0DE;
        k0 = n;
        bus0.cpu_wr = 1'b0; bus0.cpu_addr = 23'h000042; bus0.cpu_be = 2'b11; bus0.cpu_req = 1'b1;
        cs = 0;
        e1 = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus0.mem_cs) cs++;
            if (bus0.cpu_ack) begin e1 = n; break; end
        end
        bus0.cpu_req = 1'b0;
        chk("w0_latency", 32'(e1 - k0), 32'd3);
        chk("w0_cs_cycles", 32'(cs), 32'd1);
        chk("w0_rdata", 32'(bus0.cpu_rdata), 32'hC0DE);

        // randomized traffic against the model
        tick();
        rnd_rd = 1'b1;
        fork
            begin : cpu_drv
                for (int i = 0; i < 40; i++) begin
                    int e, c, gap;
                    gap = $urandom_range(0, 3);
                    if (gap != 0) begin
                        bus.cpu_req = 1'b0;
                        repeat (gap) tick();
                    end
                    set_cpu(1'($urandom), 23'($urandom), 16'($urandom), 2'($urandom));
                    wait_ack(1'b0, e, c);
                end
                bus.cpu_req = 1'b0;
            end
            begin : dma_drv
                for (int i = 0; i < 40; i++) begin
                    int e, c, gap;
                    gap = $urandom_range(0, 4);
                    if (gap != 0) begin
                        bus.dma_req = 1'b0;
                        repeat (gap) tick();
                    end
                    set_dma(1'($urandom), 23'($urandom), 16'($urandom), 2'($urandom));
                    wait_ack(1'b1, e, c);
                end
                bus.dma_req = 1'b0;
            end
        join
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning extra memory cycles held per access beyond the first (legal range 0..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports cpu_req/dma_req  input  1  access request, held high until the matching ack.
REQ-005 SHALL have ports cpu_wr/dma_wr  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports cpu_addr/dma_addr  input  23  word address [23:1].
REQ-007 SHALL have ports cpu_wdata/dma_wdata  input  16  write data.
REQ-008 SHALL have ports cpu_be/dma_be  input  2  byte enables {high, low}.
REQ-009 SHALL have ports cpu_ack/dma_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports cpu_rdata/dma_rdata  output  16  registered read data, valid from the ack cycle until the next ack to that requester.
REQ-011 SHALL have ports mem_cs  output  1, mem_wr  output  1, mem_addr  output  23, mem_wdata  output  16, mem_high/mem_low  output  1  shared memory-port drive.
REQ-012 SHALL have port mem_rdata  input  16  memory-port read data.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-014 In IDLE with any request high, SHALL latch the winner's wr/addr/wdata/be and a grant flag, then move to ACCESS on the next edge.
REQ-015 Arbitration SHALL be round-robin: on simultaneous requests the grant goes to the requester not granted last; after reset, CPU wins the first tie.
REQ-016 In ACCESS, mem_cs SHALL be high for exactly WAIT_CYCLES+1 cycles, driven from a down-counter loaded in IDLE.
REQ-017 mem_wr, mem_addr, mem_wdata, mem_high and mem_low SHALL be stable for the whole ACCESS window; mem_wr high only when the latched wr = 1.
REQ-018 On the last ACCESS cycle, SHALL capture mem_rdata into the granted requester's rdata register for reads; write grants SHALL leave rdata unchanged.
REQ-019 In DONE, SHALL pulse the granted requester's ack for one cycle, then return to IDLE.
REQ-020 Latency from req sampled in IDLE to ack SHALL be WAIT_CYCLES+3 cycles.
REQ-021 Outside ACCESS, mem_cs and mem_wr SHALL be 0, and mem_high/mem_low SHALL be 0.
REQ-022 A requester SHALL drop req in the cycle after ack; req still high in the IDLE cycle following DONE SHALL be treated as a new request.
REQ-023 A req that falls mid-access SHALL NOT abort the access; the ack still pulses.
REQ-024 Both acks SHALL never be high in the same cycle.
REQ-025 With WAIT_CYCLES = 0, ACCESS SHALL last exactly one cycle.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, last-grant = DMA (CPU wins the first tie), mem_* outputs 0, acks 0, and rdata registers to 16'h0000.
REQ-027 rst asserted mid-ACCESS SHALL drop mem_cs at the next edge and SHALL NOT produce an ack for the aborted access.

Structure
REQ-028 A shared package SHALL hold the state enumeration and requester-index constants (REQ_CPU = 0, REQ_DMA = 1).
REQ-029 The round-robin selector SHALL be one sub-module, rr_arbiter2 (inputs: two requests and last grant; output: one-hot grant).

Verification
REQ-030 Single CPU read at 0x0A0000, WAIT_CYCLES = 2, mem_rdata = 16'hBEEF -> mem_cs high 3 cycles, cpu_ack 5 cycles after req, cpu_rdata = 16'hBEEF.
REQ-031 cpu_req and dma_req rise together after reset -> CPU served first, then DMA; exactly one ack per cycle at most.
REQ-032 Both requesters held continuously for 6 accesses -> grants alternate CPU, DMA, CPU, DMA, CPU, DMA.
REQ-033 DMA write 16'h1234 at addr 0x1FF800 with be = 2'b10 -> mem_wr = 1, mem_high = 1, mem_low = 0 for the full window; dma_rdata unchanged.
REQ-034 rst pulsed on the second ACCESS cycle -> mem_cs = 0 on the next edge, no ack, FSM in IDLE; next CPU request completes normally.
REQ-035 WAIT_CYCLES = 0 build, CPU read -> mem_cs high 1 cycle, ack 3 cycles after req.
